// File: rtl/char_rotator.sv
// rtl/char_rotator.sv - timed/manual 3-slot rotator for the dE1 HEX character path
module char_rotator #(
    parameter int TICK_DIV = 50000000,
    parameter int CNT_W    = 26
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic [1:0] Ch2,
    input  logic [1:0] Ch1,
    input  logic [1:0] Ch0,
    input  logic       Run,
    input  logic       Dir,
    input  logic       StepN,
    output logic [1:0] Rot_Sel,
    output logic [1:0] Slot2,
    output logic [1:0] Slot1,
    output logic [1:0] Slot0,
    output logic       Tick
);

    localparam logic [1:0] R0 = 2'b00;
    localparam logic [1:0] R1 = 2'b01;
    localparam logic [1:0] R2 = 2'b10;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic             step_s1;
    logic             step_s2;
    logic             step_prev;
    logic             step_pulse;
    logic [CNT_W-1:0] cnt;
    logic             auto_adv;
    logic             adv;
    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [5:0]       slots_next;

    // StepN is a raw button: two-flop synchronizer, then one pulse per falling edge
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            step_s1   <= 1'b1;
            step_s2   <= 1'b1;
            step_prev <= 1'b1;
        end else begin
            step_s1   <= StepN;
            step_s2   <= step_s1;
            step_prev <= step_s2;
        end
    end

    assign step_pulse = step_prev & ~step_s2;
    assign auto_adv   = Run && (cnt == CNT_LAST);
    assign adv        = auto_adv | step_pulse;

    // A manual step restarts the period so the next auto advance is a full TICK_DIV away
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            cnt <= '0;
        end else if (step_pulse) begin
            cnt <= '0;
        end else if (Run) begin
            if (cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            R0:      if (adv) state_next = Dir ? R2 : R1;
            R1:      if (adv) state_next = Dir ? R0 : R2;
            R2:      if (adv) state_next = Dir ? R1 : R0;
            default: state_next = R0;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            state <= R0;
            Tick  <= 1'b0;
        end else begin
            state <= state_next;
            Tick  <= adv;
        end
    end

    assign Rot_Sel = state;

    always_comb begin
        slots_next = {Ch2, Ch1, Ch0};
        case (state)
            R1:      slots_next = {Ch1, Ch0, Ch2};
            R2:      slots_next = {Ch0, Ch2, Ch1};
            default: slots_next = {Ch2, Ch1, Ch0};
        endcase
    end

    // Slots follow the registered state, so they trail Rot_Sel by one cycle
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            Slot2 <= 2'b00;
            Slot1 <= 2'b00;
            Slot0 <= 2'b00;
        end else begin
            Slot2 <= slots_next[5:4];
            Slot1 <= slots_next[3:2];
            Slot0 <= slots_next[1:0];
        end
    end

endmodule

// File: tb/tb_char_rotator.sv
// tb/tb_char_rotator.sv - scoreboard bench for char_rotator with TICK_DIV=4
module tb_char_rotator;

    logic       clk;
    logic       Resetn;
    logic [1:0] Ch2;
    logic [1:0] Ch1;
    logic [1:0] Ch0;
    logic       Run;
    logic       Dir;
    logic       StepN;
    logic [1:0] Rot_Sel;
    logic [1:0] Slot2;
    logic [1:0] Slot1;
    logic [1:0] Slot0;
    logic       Tick;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc_no  = 0;
    int         last_tick = 0;
    logic [7:0] exp_q[$];

    char_rotator #(.TICK_DIV(4), .CNT_W(2)) dut (
        .CLOCK_50 (clk),
        .Resetn   (Resetn),
        .Ch2      (Ch2),
        .Ch1      (Ch1),
        .Ch0      (Ch0),
        .Run      (Run),
        .Dir      (Dir),
        .StepN    (StepN),
        .Rot_Sel  (Rot_Sel),
        .Slot2    (Slot2),
        .Slot1    (Slot1),
        .Slot0    (Slot0),
        .Tick     (Tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        cyc_no++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference rotation table: which input lands on each display slot
    function automatic logic [5:0] rot_slots(input logic [1:0] r);
        case (r)
            2'b01:   return {Ch1, Ch0, Ch2};
            2'b10:   return {Ch0, Ch2, Ch1};
            default: return {Ch2, Ch1, Ch0};
        endcase
    endfunction

    task automatic push(input logic [1:0] r);
        exp_q.push_back({r, rot_slots(r)});
    endtask

    task automatic wait_adv(input string tag, input int max, output int lat);
        logic [7:0] e;
        bit found;
        found = 1'b0;
        lat = 0;
        while (!found && lat < max) begin
            step();
            lat++;
            found = (Tick === 1'b1);
        end
        check({tag, "_seen"}, 32'(found), 32'd1);
        if (found) begin
            last_tick = cyc_no;
            check({tag, "_queued"}, 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({tag, "_rot"}, 32'(Rot_Sel), 32'(e[7:6]));
                step();
                check({tag, "_tick_width"}, 32'(Tick), 32'd0);
                check({tag, "_slots"}, 32'({Slot2, Slot1, Slot0}), 32'(e[5:0]));
            end
        end
    endtask

    initial begin
        int lat;
        int prev;
        int start;

        Resetn = 1'b0;
        Ch2 = 2'b00; Ch1 = 2'b01; Ch0 = 2'b10;
        Run = 1'b0; Dir = 1'b0; StepN = 1'b1;
        step();
        check("rst_rot", 32'(Rot_Sel), 32'd0);
        check("rst_slots", 32'({Slot2, Slot1, Slot0}), 32'd0);
        check("rst_tick", 32'(Tick), 32'd0);

        Resetn = 1'b1;
        step();
        check("rel_slots", 32'({Slot2, Slot1, Slot0}), 32'(6'b00_01_10));
        check("rel_rot", 32'(Rot_Sel), 32'd0);
        repeat (10) begin
            step();
            check("idle_rot", 32'(Rot_Sel), 32'd0);
            check("idle_tick", 32'(Tick), 32'd0);
        end

        // automatic forward rotation
        Run = 1'b1;
        push(2'b01); push(2'b10); push(2'b00);
        wait_adv("fwd0", 8, lat);
        check("fwd0_lat", 32'(lat), 32'd4);
        prev = last_tick;
        for (int i = 0; i < 2; i++) begin
            wait_adv("fwd", 8, lat);
            check("fwd_period", 32'(last_tick - prev), 32'd4);
            prev = last_tick;
        end

        // reverse rotation
        Dir = 1'b1;
        push(2'b10); push(2'b01);
        for (int i = 0; i < 2; i++) begin
            wait_adv("rev", 8, lat);
            check("rev_period", 32'(last_tick - prev), 32'd4);
            prev = last_tick;
        end

        // Dir toggles between ticks: no extra advance, last value wins
        Dir = 1'b0;
        step();
        check("dir_toggle_tick", 32'(Tick), 32'd0);
        Dir = 1'b1;
        step();
        check("dir_toggle_tick", 32'(Tick), 32'd0);
        Dir = 1'b0;
        push(2'b10);
        wait_adv("dir_new", 8, lat);
        check("dir_new_period", 32'(last_tick - prev), 32'd4);

        // manual presses held long: one advance each, 3-cycle latency
        Run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(2'(i));
            StepN = 1'b0;
            wait_adv("step", 6, lat);
            check("step_lat", 32'(lat), 32'd3);
            repeat (16) begin
                step();
                check("step_hold_tick", 32'(Tick), 32'd0);
            end
            StepN = 1'b1;
            repeat (4) step();
        end

        // step_pulse lands on the cycle where the prescaler wraps
        Run = 1'b1;
        start = cyc_no;
        step();
        StepN = 1'b0;
        push(2'b00);
        wait_adv("coll", 8, lat);
        check("coll_when", 32'(last_tick - start), 32'd4);
        prev = last_tick;
        push(2'b01);
        wait_adv("coll_next", 8, lat);
        check("coll_next_period", 32'(last_tick - prev), 32'd4);

        // pause at count 2, live Ch0 change while in R1
        step();
        Run = 1'b0;
        StepN = 1'b1;
        Ch0 = 2'b11;
        step();
        check("live_slot1", 32'(Slot1), 32'(2'b11));
        check("live_slots", 32'({Slot2, Slot1, Slot0}), 32'(rot_slots(2'b01)));
        repeat (9) begin
            step();
            check("pause_tick", 32'(Tick), 32'd0);
        end
        Run = 1'b1;
        push(2'b10);
        wait_adv("resume", 4, lat);
        check("resume_lat", 32'(lat), 32'd2);

        // asynchronous reset mid-count
        step();
        step();
        #2;
        Resetn = 1'b0;
        #1;
        check("async_rst_rot", 32'(Rot_Sel), 32'd0);
        check("async_rst_slots", 32'({Slot2, Slot1, Slot0}), 32'd0);
        check("async_rst_tick", 32'(Tick), 32'd0);
        step();
        Ch0 = 2'b10;
        Run = 1'b0;
        Resetn = 1'b1;
        step();
        check("rerel_slots", 32'({Slot2, Slot1, Slot0}), 32'(6'b00_01_10));
        repeat (12) begin
            step();
            check("rerel_rot", 32'(Rot_Sel), 32'd0);
            check("rerel_tick", 32'(Tick), 32'd0);
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/char_rotator.md
Name: char_rotator

Overview:
- Sequential upstream stage for the 3-character HEX display path (2-bit character codes: 00='d', 01='E', 10='1', 11=blank).
- Replaces the manual SW[9:8] rotation select with a timed rotator.
- Advances the 3-slot rotation automatically on a prescaled tick, or manually on a debounced-free push-button edge.
- Emits the rotation select and the three rotated 2-bit codes, registered, for the downstream 7-segment decoders.

Parameters:
- TICK_DIV, 50000000: CLOCK_50 cycles per automatic advance (1 s at 50 MHz); must be >= 2.
- CNT_W, 26: prescaler width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- CLOCK_50  input  1  system clock, rising edge.
- Resetn  input  1  asynchronous active-low reset.
- Ch2  input  2  code for leftmost slot at rotation 0 (from SW[5:4]).
- Ch1  input  2  code for middle slot at rotation 0 (from SW[3:2]).
- Ch0  input  2  code for rightmost slot at rotation 0 (from SW[1:0]).
- Run  input  1  1 = automatic advance enabled; 0 = paused.
- Dir  input  1  0 = forward (dE1 -> E1d -> 1dE), 1 = reverse.
- StepN  input  1  asynchronous active-low push button; each press advances one position.
- Rot_Sel  output  2  current rotation: 00, 01 or 10; 11 never driven.
- Slot2  output  2  code for HEX2.
- Slot1  output  2  code for HEX1.
- Slot0  output  2  code for HEX0.
- Tick  output  1  one-cycle pulse on every advance, automatic or manual.

Behaviour:
- Reset (Resetn=0, asynchronous):
  - Rot_Sel=00, Slot2/1/0=00, Tick=0, prescaler=0.
  - StepN synchronizer flops and edge-detect flop all =1.
- Recovery is synchronous: the first clock edge after Resetn rises evaluates normally. Reset asserted mid-count or mid-press returns to rotation 00 immediately.
- StepN handling:
  - Two-flop synchronizer, then falling-edge detect (previous synced value 1, current 0) -> step_pulse for one cycle.
  - A held button yields exactly one pulse. No debounce in this block.
- Prescaler, when Run=1:
  - Increments each cycle.
  - At count == TICK_DIV-1, asserts internal auto_adv and wraps to 0.
- Prescaler, when Run=0: holds its value; auto_adv=0.
- Rotation FSM, states R0 (00), R1 (01), R2 (10); adv = auto_adv OR step_pulse.
  - Forward: R0 -> R1 -> R2 -> R0.
  - Reverse: R0 -> R2 -> R1 -> R0.
  - Illegal 11: next state R0 on any cycle.
- Simultaneous auto_adv and step_pulse:
  - Single advance only; Tick pulses once.
  - Prescaler restarts at 0.
- Any step_pulse clears the prescaler to 0, so the next auto advance comes a full TICK_DIV cycles later. This applies whether Run is 0 or 1.
- Dir is sampled on the advancing cycle. A change takes effect on the next advance and never causes an advance itself.
- Tick is registered: high in the cycle Rot_Sel shows the new value.
- Slot outputs are registered from the current state and live Ch inputs:
  - R0: Slot2=Ch2, Slot1=Ch1, Slot0=Ch0.
  - R1: Slot2=Ch1, Slot1=Ch0, Slot0=Ch2.
  - R2: Slot2=Ch0, Slot1=Ch2, Slot0=Ch1.
  - Slots update one cycle after the state change, and one cycle after a Ch input change.
- Latencies:
  - StepN fall to Rot_Sel change: 3 cycles.
  - StepN fall to slot change: 4 cycles.

Test Plan:
- Reset: TICK_DIV=4; Resetn=0 asynchronously mid-operation -> all outputs 0 immediately. Release with Ch2=00, Ch1=01, Ch0=10, Run=0 -> next edge Slot2/1/0=00/01/10, Rot_Sel stays 00 indefinitely.
- Auto forward: Run=1, Dir=0 -> Tick every 4 cycles. Rot_Sel sequence 00,01,10,00; slots go 00/01/10 -> 01/10/00 -> 10/00/01 -> 00/01/10.
- Reverse: Run=1, Dir=1 from R0 -> Rot_Sel 10 then 01 then 00. Toggle Dir between ticks -> no extra Tick; next advance uses the new direction.
- Manual step: Run=0, StepN held low 20 cycles -> exactly one Tick, Rot_Sel 00 -> 01 three cycles after the fall. Release and press again -> 10.
- Collision: Run=1, StepN fall timed so step_pulse coincides with count==3 -> one Tick, single advance, next auto Tick exactly 4 cycles later.
- Pause and live data: Run=1 -> 0 at count 2, wait 10 cycles, Run=1 -> Tick after 2 more cycles. Change Ch0 to 11 while in R1 -> Slot1=11 one cycle later.
